// File: rtl/reg_file_dbg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_dbg
// Description : Parametrised integer register file for the RV32IMF core.
//               One write port and NREAD combinational read ports with
//               write-to-read bypass. Register 0 can be hard-wired to zero.
//               A debug dump engine streams {value, index} words over a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_dbg #(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int NREAD   = 2,
  parameter  int ZERO_X0 = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  WRITE_EN,
  input  logic [AW-1:0]         IN_ADDRESS,
  input  logic [XLEN-1:0]       DATA_IN,
  input  logic [NREAD*AW-1:0]   OUT_ADDRESS,
  output logic [NREAD*XLEN-1:0] DATA_OUT,
  input  logic                  DBG_START,
  input  logic                  DBG_READY,
  output logic                  DBG_VALID,
  output logic [XLEN+7:0]       DBG_DATA,
  output logic                  DBG_BUSY,
  output logic                  DBG_DONE
);

  // Widened by one bit so that NREGS itself is representable for range checks.
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    FIN  = 2'd3
  } dbg_state_t;

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_ok;

  dbg_state_t      r_state;
  logic [AW-1:0]   r_idx;
  logic            r_valid;
  logic [XLEN+7:0] r_data;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] w_load_val;

  // A write commits only when in range and not aimed at a hard-wired x0.
  assign w_wr_ok = WRITE_EN && ({1'b0, IN_ADDRESS} < NREGS_W) &&
                   !((ZERO_X0 != 0) && (IN_ADDRESS == '0));

  // Register array storage.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[IN_ADDRESS] <= DATA_IN;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rdata;

    assign addr = OUT_ADDRESS[k*AW +: AW];

    // Read mux: out-of-range and hard-wired x0 read zero, pending write bypasses.
    always_comb begin
      rdata = '0;
      if (({1'b0, addr} < NREGS_W) && !((ZERO_X0 != 0) && (addr == '0))) begin
        if (w_wr_ok && (IN_ADDRESS == addr)) begin
          rdata = DATA_IN;
        end else begin
          rdata = r_regs[addr];
        end
      end
    end

    assign DATA_OUT[k*XLEN +: XLEN] = rdata;
  end

  // Dump words carry the committed value, never the bypassed write data.
  assign w_load_val = ((ZERO_X0 != 0) && (r_idx == '0)) ? '0 : r_regs[r_idx];

  // Debug dump engine: one word per LOAD/SHOW pair, DONE pulses in FIN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (DBG_START) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_data  <= {w_load_val, 8'(r_idx)};
          r_valid <= 1'b1;
          r_state <= SHOW;
        end
        SHOW: begin
          if (DBG_READY) begin
            r_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= LOAD;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign DBG_VALID = r_valid;
  assign DBG_DATA  = r_data;
  assign DBG_BUSY  = r_busy;
  assign DBG_DONE  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_dbg.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_dbg
// Description : Self-checking bench for reg_file_dbg. Default build is checked
//               against an array reference model under random traffic; a
//               second NREGS=24 / NREAD=3 build gets directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_dbg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
  localparam int N2    = 24;
  localparam int R2    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default build
  logic                  we = 0, start = 0, ready = 0;
  logic [AW-1:0]         waddr = '0;
  logic [XLEN-1:0]       wdata = '0;
  logic [NREAD*AW-1:0]   raddr = '0;
  logic [NREAD*XLEN-1:0] rdata;
  logic                  valid, busy, done;
  logic [XLEN+7:0]       ddata;

  // small build
  logic                  we2 = 0, start2 = 0, ready2 = 0;
  logic [4:0]            waddr2 = '0;
  logic [XLEN-1:0]       wdata2 = '0;
  logic [R2*5-1:0]       raddr2 = '0;
  logic [R2*XLEN-1:0]    rdata2;
  logic                  valid2, busy2, done2;
  logic [XLEN+7:0]       ddata2;

  reg_file_dbg #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_X0(1)) dut (
    .CLK(clk), .RESET_N(rst_n), .WRITE_EN(we), .IN_ADDRESS(waddr), .DATA_IN(wdata),
    .OUT_ADDRESS(raddr), .DATA_OUT(rdata), .DBG_START(start), .DBG_READY(ready),
    .DBG_VALID(valid), .DBG_DATA(ddata), .DBG_BUSY(busy), .DBG_DONE(done)
  );

  reg_file_dbg #(.XLEN(XLEN), .NREGS(N2), .NREAD(R2), .ZERO_X0(1)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .WRITE_EN(we2), .IN_ADDRESS(waddr2), .DATA_IN(wdata2),
    .OUT_ADDRESS(raddr2), .DATA_OUT(rdata2), .DBG_START(start2), .DBG_READY(ready2),
    .DBG_VALID(valid2), .DBG_DATA(ddata2), .DBG_BUSY(busy2), .DBG_DONE(done2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [XLEN-1:0] model [NREGS];
  logic [XLEN-1:0] pre   [NREGS];
  bit              busy_exp = 0, done_exp = 0, xfer = 0, valid_prev = 0;
  int              exp_idx = 0, words = 0;
  logic [XLEN+7:0] data_prev = '0;

  function automatic logic [XLEN-1:0] ref_read(input int a);
    if (a >= NREGS || a == 0) return '0;
    if (we && int'(waddr) == a && waddr != 0) return wdata;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    busy_exp = 0; done_exp = 0; xfer = 0; valid_prev = 0;
    exp_idx = 0; words = 0; data_prev = '0;
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic tick();
    bit new_done;
    #1;
    for (int k = 0; k < NREAD; k++)
      check($sformatf("rd%0d", k), rdata[k*XLEN +: XLEN], ref_read(int'(raddr[k*AW +: AW])));
    xfer = valid && ready;
    pre = model;
    @(posedge clk);
    if (we && waddr != 0) model[waddr] = wdata;
    new_done = xfer && (exp_idx == NREGS - 1);
    if (xfer) begin words++; exp_idx++; end
    if (done_exp) busy_exp = 0;
    else if (!busy_exp && start) begin busy_exp = 1; exp_idx = 0; words = 0; end
    done_exp = new_done;
    @(negedge clk);
    check("busy", busy, busy_exp);
    check("done", done, done_exp);
    if (done_exp) check("word_count", words, NREGS);
    if (!busy_exp) check("idle_valid", valid, 0);
    if (xfer) check("valid_after_xfer", valid, 0);
    else if (valid_prev) begin
      check("hold_valid", valid, 1);
      check("hold_data", ddata, data_prev);
    end
    if (valid && !valid_prev) begin
      if (exp_idx < NREGS) check("word", ddata, {pre[exp_idx], 8'(exp_idx)});
      else check("word_idx", exp_idx, NREGS - 1);
    end
    valid_prev = valid;
    data_prev  = ddata;
  endtask

  task automatic rnd_inputs(input bit allow_start);
    we    = 1'($urandom_range(0, 1));
    waddr = AW'($urandom_range(0, NREGS - 1));
    wdata = $urandom;
    raddr = {AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1))};
    if ($urandom_range(0, 3) == 0) raddr[AW +: AW] = waddr;
    ready = 1'($urandom_range(0, 1));
    start = allow_start && ($urandom_range(0, 7) == 0);
  endtask

  task automatic quiet_inputs();
    we = 0; start = 0; ready = 1;
    raddr = {AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1))};
  endtask

  // Runs the current dump to its DONE cycle, then one more cycle.
  task automatic run_to_done(input int bound, input bit rnd);
    int c;
    for (c = 0; c < bound && !done_exp; c++) begin
      if (rnd) rnd_inputs(1'b1); else quiet_inputs();
      tick();
    end
    check("dump_finished", done_exp, 1);
    quiet_inputs();
    tick();
  endtask

  task automatic pulse_start();
    quiet_inputs();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    int c, cnt;
    clear_model();
    #12;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", ddata, 0);
    check("rst_rd0", rdata[31:0], 0);
    @(negedge clk);
    rst_n = 1;

    // write x5 then read on both ports; x0 write dropped
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {5'd5, 5'd5}; tick();
    we = 0; tick();
    check("x5_p0", rdata[31:0], 32'hDEADBEEF);
    check("x5_p1", rdata[63:32], 32'hDEADBEEF);
    we = 1; waddr = 0; wdata = 32'h1234; raddr = {5'd0, 5'd0}; tick();
    we = 0; tick();
    // bypass on port 1
    we = 1; waddr = 7; wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd0};
    #1 check("bypass_p1", rdata[63:32], 32'hA5A5A5A5);
    tick();

    // x_i = i*0x11, then a full dump with READY held high
    for (int i = 0; i < NREGS; i++) begin
      we = 1; waddr = AW'(i); wdata = i * 32'h11; raddr = {AW'(i), 5'd0}; tick();
    end
    we = 0;
    pulse_start();
    run_to_done(200, 0);

    // stall at idx 3 while overwriting x3 and re-requesting start
    pulse_start();
    for (c = 0; c < 50 && !(valid && exp_idx == 3); c++) begin quiet_inputs(); tick(); end
    check("reach_idx3", exp_idx, 3);
    for (int h = 0; h < 5; h++) begin
      ready = 0; we = 1; waddr = 3; wdata = 32'hFFFF0000; start = 1;
      tick();
      check("hold_x3", ddata, {32'h33, 8'd3});
    end
    run_to_done(200, 0);

    // random dump with random writes, backpressure and stray starts
    pulse_start();
    run_to_done(600, 1);

    // asynchronous reset in the middle of a dump
    pulse_start();
    for (c = 0; c < 100 && !(valid && exp_idx == 10); c++) begin quiet_inputs(); tick(); end
    check("reach_idx10", exp_idx, 10);
    we = 0; start = 0;
    #2 rst_n = 0;
    #1;
    clear_model();
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int a = 1; a < NREGS; a += 7) begin
      raddr = {AW'(a), AW'(a + 1)};
      #1 check("abort_rd", rdata, 0);
    end
    @(negedge clk);
    rst_n = 1;
    pulse_start();
    run_to_done(200, 0);

    // free random traffic with occasional dumps
    for (int i = 0; i < 400; i++) begin rnd_inputs(1'b1); tick(); end
    run_to_done(600, 1);

    // NREGS=24, NREAD=3 build
    @(negedge clk);
    we2 = 1; waddr2 = 5; wdata2 = 32'h55;
    @(negedge clk);
    we2 = 1; waddr2 = 28; wdata2 = 32'hFFFFFFFF; raddr2 = {5'd28, 5'd30, 5'd5};
    #1;
    check("s_rd5", rdata2[31:0], 32'h55);
    check("s_rd30", rdata2[63:32], 0);
    check("s_rd28_bypass", rdata2[95:64], 0);
    @(negedge clk);
    we2 = 0;
    #1;
    check("s_rd28", rdata2[95:64], 0);
    check("s_rd5b", rdata2[31:0], 32'h55);
    @(negedge clk);
    start2 = 1; ready2 = 1;
    @(negedge clk);
    start2 = 0;
    cnt = 0;
    for (c = 0; c < 200 && !done2; c++) begin
      if (valid2) begin
        check("s_word", ddata2, {(cnt == 5) ? 32'h55 : 32'h0, 8'(cnt)});
        cnt++;
      end
      @(negedge clk);
    end
    check("s_done", done2, 1);
    check("s_count", cnt, N2);
    @(negedge clk);
    check("s_busy_end", busy2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_dbg.md
Name: reg_file_dbg

Overview:
Parametrised integer register file for the RV32IMF core. It has one write port, NREAD combinational read ports with write-to-read bypass, and an optional hard-wired zero register. A built-in debug dump engine streams every register, tagged with its index, over a valid/ready handshake to the LED/UART debug path. This replaces the fixed-width, fixed-port register file and its free-running index-select debug output.

Parameters:
XLEN, 32, register data width in bits
NREGS, 32, number of registers (2..256)
NREAD, 2, number of read ports
ZERO_X0, 1, 1 = register 0 always reads 0 and ignores writes
AW, $clog2(NREGS), localparam: address width

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET_N  in  1  asynchronous, active-low reset
WRITE_EN  in  1  write strobe
IN_ADDRESS  in  AW  write address
DATA_IN  in  XLEN  write data
OUT_ADDRESS  in  NREAD*AW  packed read addresses; port k occupies bits [k*AW +: AW]
DATA_OUT  out  NREAD*XLEN  packed read data; port k occupies bits [k*XLEN +: XLEN]
DBG_START  in  1  request a full register dump; single-cycle pulse
DBG_READY  in  1  sink can accept DBG_DATA
DBG_VALID  out  1  DBG_DATA holds a valid word
DBG_DATA  out  XLEN+8  {register value, 8-bit register index}
DBG_BUSY  out  1  dump in progress
DBG_DONE  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (RESET_N=0, async): all registers 0; FSM to IDLE; DBG_VALID=0, DBG_DATA=0, DBG_BUSY=0, DBG_DONE=0. DATA_OUT follows the zeroed array combinationally.
- Write: on posedge CLK, when WRITE_EN=1 and IN_ADDRESS<NREGS, REG[IN_ADDRESS]<=DATA_IN.
  - If ZERO_X0=1, writes to address 0 are dropped.
  - IN_ADDRESS>=NREGS: write ignored.
- Read is combinational, zero latency. DATA_OUT[k]:
  - 0 if the address >= NREGS, or if the address is 0 and ZERO_X0=1;
  - else DATA_IN if WRITE_EN=1 and IN_ADDRESS equals the read address and the write is not dropped (bypass);
  - else REG[addr].
  - Ports are independent; identical addresses on several ports return identical data.
- Debug FSM states: IDLE, LOAD, SHOW, FIN.
  - IDLE: DBG_START=1 -> LOAD with idx=0; DBG_BUSY=1 from the next cycle.
  - LOAD (1 cycle): DBG_DATA<={REG[idx] (post-reset/committed value; 0 for x0 when ZERO_X0=1), idx zero-extended to 8 bits}; DBG_VALID<=1; -> SHOW.
  - SHOW: DBG_DATA and DBG_VALID are held stable while DBG_READY=0. A write to REG[idx] during this hold does not alter DBG_DATA.
  - SHOW with DBG_READY=1 (transfer):
    - if idx==NREGS-1: DBG_VALID<=0, -> FIN;
    - else idx<=idx+1, DBG_VALID<=0, -> LOAD.
    - A word is therefore presented at most every 2 cycles.
  - FIN (1 cycle): DBG_DONE=1; DBG_BUSY<=0; -> IDLE.
  - DBG_START outside IDLE is ignored; a new dump never restarts an active one.
- DBG_DATA keeps its last value after a dump; DBG_VALID=0 there.
- Dump and normal read/write operate concurrently; a dump never stalls WRITE_EN or the read ports.
- Each register's value is sampled at its own LOAD cycle. Writes landing in that same LOAD cycle are not visible in that word (pre-edge value).
- Asserting RESET_N=0 mid-dump aborts immediately: DBG_VALID=0, no DBG_DONE pulse.

Test Plan:
- Reset, then write 0xDEADBEEF to x5 and read x5 on port 0 and port 1 -> both return 0xDEADBEEF one cycle after the write; x0 write of 0x1234 -> x0 reads 0.
- Same cycle WRITE_EN=1, IN_ADDRESS=7, DATA_IN=0xA5A5A5A5, OUT_ADDRESS port1=7 -> DATA_OUT port1=0xA5A5A5A5 combinationally (bypass); x0 with ZERO_X0=1 -> 0.
- Load x_i=i*0x11 for all i, pulse DBG_START with DBG_READY=1 -> 32 words {i*0x11, i} for i=0..31, each on alternate cycles; DBG_DONE is a single pulse after word 31; then BUSY=0.
- During a dump hold DBG_READY=0 for 5 cycles at idx=3 while writing x3=0xFFFF0000 -> DBG_DATA stays {old x3, 8'd3}, VALID stays 1, and there is no extra DBG_START restart.
- Deassert RESET_N during idx=10 of a dump -> VALID=0, BUSY=0, no DONE, and all registers read 0. A new DBG_START then gives a full dump starting at idx 0.
- NREGS=24, NREAD=3 build: read address 30 -> 0; write address 28 -> no change; dump emits exactly 24 words.
